// File: rtl/imm_pack.sv
// Two-stage valid/ready pipeline packing a 32-bit value into a 24-bit immediate plus a fit flag.
// Latency 2 cycles; full throughput; optional fit-error counter under IMM_PACK_ERRCNT_EN.
module imm_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm32,
    input  logic [1:0]  Extop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] imm,
    output logic        fit,
    output logic [7:0]  err_cnt
);
    logic        s1_vld;
    logic [31:0] s1_dat;
    logic [1:0]  s1_ext;
    logic        s2_vld;
    logic        s2_free;
    logic [23:0] pk_imm;
    logic        pk_fit;

    // S2 can take a new entry when empty or being drained; S1 can when empty or moving on.
    assign s2_free   = !s2_vld || out_ready;
    assign in_ready  = !s1_vld || s2_free;
    assign out_valid = s2_vld;

    always_comb begin
        pk_imm = 24'h000000;
        pk_fit = 1'b0;
        case (s1_ext)
            2'b00: begin
                pk_imm = {8'h00, s1_dat[15:0]};
                pk_fit = (s1_dat[31:16] == 16'h0000);
            end
            2'b01: begin
                pk_imm = {8'h00, s1_dat[15:0]};
                pk_fit = (&s1_dat[31:15]) || (~|s1_dat[31:15]);
            end
            2'b10: begin
                pk_imm = s1_dat[23:0];
                pk_fit = (&s1_dat[31:23]) || (~|s1_dat[31:23]);
            end
            default: begin
                pk_imm = 24'h000000;
                pk_fit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= 32'h0;
            s1_ext <= 2'b00;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= imm32;
                s1_ext <= Extop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            imm    <= 24'h000000;
            fit    <= 1'b0;
        end else if (s2_free) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                imm <= pk_imm;
                fit <= pk_fit;
            end
        end
    end

`ifdef IMM_PACK_ERRCNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'h00;
        end else if (s2_vld && out_ready && !fit && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'h01;
        end
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed self-checking bench for imm_pack: vector table, stall/order, mid-stream reset, counter saturation.
module tb_imm_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm32;
    logic [1:0]  Extop;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] imm;
    logic        fit;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    imm_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm32(imm32), .Extop(Extop),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fit(fit), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  e;
        logic [23:0] x_imm;
        logic        x_fit;
    } vec_t;

    vec_t vecs[12];

`ifdef IMM_PACK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int nacc;
        int nout;
        vecs[0]  = '{32'h00001234, 2'b00, 24'h001234, 1'b1};
        vecs[1]  = '{32'hFFFF8000, 2'b01, 24'h008000, 1'b1};
        vecs[2]  = '{32'h00008000, 2'b01, 24'h008000, 1'b0};
        vecs[3]  = '{32'hFFFFFFFF, 2'b10, 24'hFFFFFF, 1'b1};
        vecs[4]  = '{32'h00800000, 2'b10, 24'h800000, 1'b0};
        vecs[5]  = '{32'h12345678, 2'b11, 24'h000000, 1'b0};
        vecs[6]  = '{32'h00010000, 2'b00, 24'h000000, 1'b0};
        vecs[7]  = '{32'h00007FFF, 2'b01, 24'h007FFF, 1'b1};
        vecs[8]  = '{32'hFF800000, 2'b10, 24'h800000, 1'b1};
        vecs[9]  = '{32'h007FFFFF, 2'b10, 24'h7FFFFF, 1'b1};
        vecs[10] = '{32'hFFFF7FFF, 2'b01, 24'h007FFF, 1'b0};
        vecs[11] = '{32'hABCD1234, 2'b00, 24'h001234, 1'b0};

        // Reset state, checked before any clock edge.
        rst = 1'b1; in_valid = 1'b0; imm32 = 32'h0; Extop = 2'b00; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm", imm, 0);
        chk("rst_fit", fit, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming table: vector c presented in cycle c emerges in cycle c+2, no bubbles.
        for (int c = 0; c < 15; c++) begin
            if (c < 12) begin
                in_valid = 1'b1; imm32 = vecs[c].a; Extop = vecs[c].e;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", in_ready, 1);
            if (c >= 2 && c < 14) begin
                chk("stream_out_valid", out_valid, 1);
                chk($sformatf("vec%0d_imm", c - 2), imm, vecs[c-2].x_imm);
                chk($sformatf("vec%0d_fit", c - 2), fit, vecs[c-2].x_fit);
            end else begin
                chk("stream_idle_out_valid", out_valid, 0);
            end
            @(negedge clk);
        end
        chk("table_err_cnt", err_cnt, CNT_EN ? 6 : 0);

        // Back-pressure: four requests, consumer stalled for cycles 0..3.
        nacc = 0; nout = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 4);
            in_valid  = (nacc < 4);
            imm32     = 32'(nacc + 1);
            Extop     = 2'b00;
            #1;
            if (c == 2 || c == 3) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_accepted", nacc, 2);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_imm_hold", imm, 24'h000001);
                chk("stall_fit_hold", fit, 1);
            end
            if (out_valid && out_ready) begin
                chk("drain_cycle", c, 4 + nout);
                chk("drain_order", imm, 24'(nout + 1));
                nout++;
            end
            if (in_valid && in_ready) nacc++;
            @(negedge clk);
        end
        chk("stall_total_in", nacc, 4);
        chk("stall_total_out", nout, 4);
        chk("stall_err_cnt", err_cnt, CNT_EN ? 6 : 0);

        // Mid-stream reset with both stages full, then the next request's latency.
        out_ready = 1'b0; Extop = 2'b11;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; imm32 = 32'hDEAD0000 + 32'(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_imm", imm, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; imm32 = 32'h00123456; Extop = 2'b10;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post_rst_lat1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        chk("post_rst_lat2_valid", out_valid, 1);
        chk("post_rst_imm", imm, 24'h123456);
        chk("post_rst_fit", fit, 1);
        @(negedge clk);
        #1;
        chk("post_rst_drained", out_valid, 0);

        // 300 reserved-mode requests drive the error counter into saturation.
        for (int c = 0; c < 300; c++) begin
            in_valid = 1'b1; imm32 = 32'(c); Extop = 2'b11;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_err_cnt", err_cnt, CNT_EN ? 8'hFF : 8'h00);
        chk("sat_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
